// File: rtl/counter_pkg.sv
// Shared encodings for the 4-bit counter harness.
// Used by the stimulus generator, counter model and counter RTL.
package counter_pkg;

  localparam logic [1:0] MODO_UP  = 2'b00;
  localparam logic [1:0] MODO_DN  = 2'b01;
  localparam logic [1:0] MODO_DN3 = 2'b10;
  localparam logic [1:0] MODO_LD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_UP   = 3'd3,
    ST_DOWN = 3'd4,
    ST_DN3  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    TGT_UP  = 2'd0,
    TGT_DN  = 2'd1,
    TGT_DN3 = 2'd2
  } tgt_e;

  function automatic logic [1:0] modo_of(state_e s);
    logic [1:0] m;
    m = MODO_UP;
    unique case (1'b1)
      (s == ST_LOAD): m = MODO_LD;
      (s == ST_DOWN): m = MODO_DN;
      (s == ST_DN3):  m = MODO_DN3;
      default:        m = MODO_UP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/counter_stimulus_lfsr4.sv
// 4-bit Fibonacci LFSR, x^4+x^3+1, period 15.
// Seed load has priority over advance; never reaches 0 from a nonzero seed.
module lfsr4 #(
  parameter logic [3:0] SEED = 4'b1001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       adv,
  output logic [3:0] q
);

  // shift left, feedback from taps 4 and 3
  always_ff @(posedge clk) begin
    if (reset || init) begin
      q <= SEED;
    end else if (adv) begin
      q <= {q[2:0], q[3] ^ q[2]};
    end
  end

endmodule

// File: rtl/counter_stimulus.sv
// Stimulus generator for the 4-bit up/down/down-3/load counter.
// Optional LFSR load data: define RAND_D_EN.
module counter_stimulus
  import counter_pkg::*;
#(
  parameter int unsigned PHASE_LEN = 16,
  parameter int unsigned CLR_LEN   = 2,
  parameter int unsigned LOOPS     = 1,
  parameter logic [3:0]  LOAD_BASE = 4'd5,
  parameter logic [3:0]  LOAD_STEP = 4'd3,
  parameter logic [3:0]  SEED      = 4'b1001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] D,
  output logic [1:0] modo,
  output logic       enable,
  output logic       busy,
  output logic       done,
  output logic [2:0] phase
);

  localparam logic [7:0] PH_LAST  = 8'(PHASE_LEN - 1);
  localparam logic [7:0] CLR_LAST = 8'(CLR_LEN - 1);
  localparam logic [3:0] LOOPS_L  = 4'(LOOPS);

  if (SEED == 4'd0) begin : g_seed_zero
    $error("SEED must be nonzero");
  end

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] loop_q, loop_d;
  tgt_e       tgt_q, tgt_d;
  logic [3:0] ld_val;

  logic       idle_like;
  logic       init;
  logic       adv;
  logic       ph_end;
  logic       last_loop;

  logic [3:0] d_n;
  logic [1:0] modo_n;
  logic       en_n;
  logic       busy_n;
  logic       done_n;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign init      = abort || (start && idle_like);
  assign adv       = (state_q == ST_LOAD) && !abort;
  assign last_loop = (loop_q + 4'd1) == LOOPS_L;
  assign phase     = state_q;

  // phase end: timer reached length-1 of the current state
  always_comb begin
    ph_end = 1'b0;
    unique case (1'b1)
      (state_q == ST_CLR):  ph_end = timer_q == CLR_LAST;
      (state_q == ST_LOAD): ph_end = 1'b1;
      (state_q == ST_UP),
      (state_q == ST_DOWN),
      (state_q == ST_DN3):  ph_end = timer_q == PH_LAST;
      default:              ph_end = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; abort wins over everything else
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) state_d = ST_CLR;
        end
        ST_CLR: begin
          if (ph_end) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          unique case (tgt_q)
            TGT_DN:  state_d = ST_DOWN;
            TGT_DN3: state_d = ST_DN3;
            default: state_d = ST_UP;
          endcase
        end
        ST_UP, ST_DOWN: begin
          if (ph_end) state_d = ST_LOAD;
        end
        ST_DN3: begin
          if (ph_end) state_d = last_loop ? ST_DONE : ST_LOAD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // next registered outputs, derived from the state being entered
  always_comb begin
    d_n    = 4'd0;
    modo_n = modo_of(state_d);
    en_n   = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    unique case (state_d)
      ST_IDLE: ;
      ST_DONE: done_n = 1'b1;
      ST_CLR:  busy_n = 1'b1;
      ST_LOAD: begin
        d_n    = ld_val;
        en_n   = 1'b1;
        busy_n = 1'b1;
      end
      default: begin
        d_n    = D;
        en_n   = 1'b1;
        busy_n = 1'b1;
      end
    endcase
  end

  // sequencing counters: timer, loop count and next counting target
  always_comb begin
    timer_d = timer_q + 8'd1;
    if (state_d != state_q || state_d == ST_IDLE ||
        state_d == ST_DONE) begin
      timer_d = 8'd0;
    end
    loop_d = loop_q;
    tgt_d  = tgt_q;
    if (init) begin
      loop_d = 4'd0;
      tgt_d  = TGT_UP;
    end else if (ph_end) begin
      unique case (state_q)
        ST_UP:   tgt_d = TGT_DN;
        ST_DOWN: tgt_d = TGT_DN3;
        ST_DN3: begin
          tgt_d  = TGT_UP;
          loop_d = loop_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= 8'd0;
      loop_q  <= 4'd0;
      tgt_q   <= TGT_UP;
      D       <= 4'd0;
      modo    <= MODO_UP;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      loop_q  <= loop_d;
      tgt_q   <= tgt_d;
      D       <= d_n;
      modo    <= modo_n;
      enable  <= en_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

`ifdef RAND_D_EN
  lfsr4 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .adv   (adv),
    .q     (ld_val)
  );
`else
  logic [3:0] ld_q;

  // arithmetic load sequence, advanced after each LOAD cycle
  always_ff @(posedge clk) begin
    if (reset || init) begin
      ld_q <= LOAD_BASE;
    end else if (adv) begin
      ld_q <= ld_q + LOAD_STEP;
    end
  end

  assign ld_val = ld_q;
`endif

endmodule

// File: tb/tb_counter_stimulus.sv
// Directed bench for counter_stimulus.
// Two instances: LOOPS=1 (a) and LOOPS=2 (b), shared inputs.
module tb_counter_stimulus;

  localparam int PL = 4;
  localparam int CL = 2;
  localparam int LOOP_LEN = 3 * (PL + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [3:0] d_a, d_b;
  logic [1:0] modo_a, modo_b;
  logic       en_a, en_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic [2:0] ph_a, ph_b;

  int checks = 0;
  int errors = 0;
  int na, nb;

  always #5 clk = ~clk;

  counter_stimulus #(
    .PHASE_LEN (PL),
    .CLR_LEN   (CL),
    .LOOPS     (1)
  ) u_a (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .D      (d_a),
    .modo   (modo_a),
    .enable (en_a),
    .busy   (busy_a),
    .done   (done_a),
    .phase  (ph_a)
  );

  counter_stimulus #(
    .PHASE_LEN (PL),
    .CLR_LEN   (CL),
    .LOOPS     (2)
  ) u_b (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .D      (d_b),
    .modo   (modo_b),
    .enable (en_b),
    .busy   (busy_b),
    .done   (done_b),
    .phase  (ph_b)
  );

  wire [11:0] va = {ph_a, busy_a, done_a, en_a, modo_a, d_a};
  wire [11:0] vb = {ph_b, busy_b, done_b, en_b, modo_b, d_b};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ld_nth(int n);
    logic [3:0] v;
`ifdef RAND_D_EN
    v = 4'b1001;
    for (int i = 0; i < n; i++) v = {v[2:0], v[3] ^ v[2]};
`else
    v = 4'(5 + 3 * n);
`endif
    return v;
  endfunction

  // {phase, busy, done, enable, modo, D} for cycle idx after start
  function automatic logic [11:0] exp_vec(int loops, int idx);
    int k, l, seg, t, c;
    logic [3:0] d;
    logic [2:0] ph;
    logic [1:0] m;
    if (idx < CL) return {3'd1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0};
    k = idx - CL;
    if (k >= loops * LOOP_LEN)
      return {3'd6, 1'b0, 1'b1, 1'b0, 2'b00, 4'd0};
    l   = k / LOOP_LEN;
    seg = k % LOOP_LEN;
    t   = seg / (PL + 1);
    c   = seg % (PL + 1);
    d   = ld_nth(l * 3 + t);
    if (c == 0) return {3'd2, 1'b1, 1'b0, 1'b1, 2'b11, d};
    ph = 3'(3 + t);
    m  = 2'(t);
    return {ph, 1'b1, 1'b0, 1'b1, m, d};
  endfunction

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int stop, input int pulse_at,
                     output int ba, output int bb);
    ba = 0;
    bb = 0;
    for (int idx = 0; idx <= stop; idx++) begin
      chk($sformatf("a_cyc%0d", idx), 32'(va), 32'(exp_vec(1, idx)));
      chk($sformatf("b_cyc%0d", idx), 32'(vb), 32'(exp_vec(2, idx)));
      if (busy_a) ba++;
      if (busy_b) bb++;
      if (idx == stop) break;
      if (idx == pulse_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_a", 32'(va), 32'd0);
    chk("reset_b", 32'(vb), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_a", 32'(va), 32'd0);

    go();
    run(34, -1, na, nb);
    chk("busy_len_a", 32'(na), 32'd17);
    chk("busy_len_b", 32'(nb), 32'd32);

    go();
    run(34, 5, na, nb);
    chk("busy_len_rep_a", 32'(na), 32'd17);
    chk("busy_len_rep_b", 32'(nb), 32'd32);

    go();
    run(9, -1, na, nb);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_a", 32'(va), 32'd0);
    chk("abort_b", 32'(vb), 32'd0);
    @(negedge clk);
    chk("abort_hold_a", 32'(va), 32'd0);

    go();
    run(20, -1, na, nb);
    chk("after_abort_busy_a", 32'(na), 32'd17);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_a", 32'(va), 32'd0);
    chk("start_abort_b", 32'(vb), 32'd0);

    go();
    run(4, -1, na, nb);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_a", 32'(va), 32'd0);
    chk("reset_mid_b", 32'(vb), 32'd0);

    go();
    run(12, -1, na, nb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_stimulus.md
Name: counter_stimulus

Overview:
Self-sequencing stimulus generator that drives the 4-bit up/down/down-3/load counter interface (D, modo, enable) and closes the test-harness loop opposite the counter model/checker. On start it runs a fixed programme per loop:
- clear
- load, count up
- load, count down
- load, count down by 3

It repeats the programme LOOPS times, then reports done. All outputs are registered so the counter and model sample stable values on the same clk edge.

Parameters:
PHASE_LEN, 16, cycles spent in each counting phase (UP, DOWN, DN3); range 1..255.
CLR_LEN, 2, cycles enable is held low in CLR; range 1..255.
LOOPS, 1, number of full programme passes before DONE; range 1..15.
LOAD_BASE, 4'd5, D value of the first load after start.
LOAD_STEP, 4'd3, added to D (mod 16) on each later load.
SEED, 4'b1001, LFSR seed when RAND_D_EN is defined; must be nonzero.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  begin programme; sampled in IDLE or DONE only
abort  input  1  synchronous abort to IDLE; priority over start
D  output  4  load data to counter
modo  output  2  00 up, 01 down, 10 down-3, 11 load
enable  output  1  counter enable; 0 clears counter and rco
busy  output  1  high in CLR..DN3
done  output  1  high in DONE
phase  output  3  current state encoding

Behaviour:
- Reset (reset=1 at an edge): state IDLE; D=0, modo=00, enable=0, busy=0, done=0, phase=0. Internal counters and load value are re-initialised. Reset mid-programme behaves identically.
- States and phase encoding: IDLE=0, CLR=1, LOAD=2, UP=3, DOWN=4, DN3=5, DONE=6.
- IDLE/DONE:
  - enable=0, modo=00, D=0.
  - start=1 at edge N: phase=CLR, busy=1, done=0 visible after edge N.
- CLR:
  - enable=0 for exactly CLR_LEN cycles, then LOAD.
- LOAD:
  - Exactly 1 cycle; enable=1, modo=11, D=current load value.
  - Next state follows the sequence UP, DOWN, DN3, tracked in a 2-bit target register.
- Counting phases:
  - UP, DOWN and DN3 each last exactly PHASE_LEN cycles with enable=1, modo=00/01/10; D holds the last loaded value.
  - After UP go to LOAD (target DOWN); after DOWN go to LOAD (target DN3).
  - After DN3: increment loop counter. If loop count equals LOOPS, go to DONE; otherwise go to LOAD (target UP). CLR is not repeated between loops.
- Load value:
  - First load of a run = LOAD_BASE.
  - Each subsequent load = previous + LOAD_STEP, 4-bit wrap (14+3 -> 1).
  - start from DONE re-initialises to LOAD_BASE.
- Phase timer: 8-bit, cleared on every state entry; a phase ends when timer == length-1.
- Busy cycles per run: CLR_LEN + LOOPS*(3 + 3*PHASE_LEN).
- abort=1 at any edge with reset=0: next state IDLE with reset-value outputs, loop/load registers re-initialised. abort and start together -> IDLE.
- start while busy: ignored.
- done stays high in DONE until start, abort or reset.

Optional Feature:
RAND_D_EN
- Defined: load value comes from a 4-bit Fibonacci LFSR, x^4+x^3+1.
  - Initialised to SEED at reset, abort, and start.
  - Advances once per LOAD cycle, after use; first load D=SEED.
  - Never 0.
  - LOAD_BASE and LOAD_STEP are unused.
- Undefined: arithmetic LOAD_BASE/LOAD_STEP sequence; no LFSR logic is synthesised.

Decomposition:
- Shared package counter_pkg:
  - modo encodings MODO_UP=2'b00, MODO_DN=2'b01, MODO_DN3=2'b10, MODO_LD=2'b11.
  - phase/state localparams.
  - These are shared with the counter model and the counter RTL.
- One natural sub-module: lfsr4, a 4-bit LFSR with seed load and advance strobe, instantiated only under RAND_D_EN.

Test Plan:
Defaults changed to PHASE_LEN=4, CLR_LEN=2, LOOPS=1 unless noted.
1. Reset, then start pulse -> phase 1 for 2 cycles (enable=0); LOAD D=5 modo=11; 4 cycles modo=00; LOAD D=8; 4 cycles modo=01; LOAD D=11; 4 cycles modo=10; then done=1, phase=6. busy high for exactly 17 cycles.
2. LOOPS=2 -> loads D=5, 8, 11, 14, 1, 4 (wrap at 14+3); no second CLR; busy for 32 cycles.
3. abort asserted in the 2nd DOWN cycle -> next cycle phase=0, enable=0, busy=0. A following start reproduces scenario 1 from D=5.
4. start re-pulsed while busy, and start+abort in the same cycle -> programme unaffected, and IDLE respectively. reset mid-UP -> all outputs return to reset values next cycle.
5. RAND_D_EN defined, SEED=4'b1001 -> load sequence per LFSR starting at 9, never 0. The full 15-state period is verified by LOOPS=5 (15 loads).
6. Counter model connected -> no mismatch across scenarios 1-2. rco checked at the DUT after the wrap points 15->0 and 2->15.
